distortion_frame_scheduler: RTL and testbench
=============================================

Name: distortion_frame_scheduler

Overview:
- Frame-granular arbiter sharing one frame-buffered distortion core between two pixel-stream sources (src0, src1).
- Grants the core to one source per frame and forwards that frame with a 1-cycle register stage.
- Drops frames from the other source while the core is busy.
- Waits for the core's output frame end, guarded by a watchdog, before granting again.

Parameters:
- WIDTH, 320, pixels per line; sizes the per-frame pixel count.
- HEIGHT, 466, lines per frame.
- DATA_WIDTH, 24, pixel width.
- TIMEOUT, 1048576, maximum DRAIN cycles before abort.
- CNT_WIDTH, 8, width of the saturating drop and done counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new grant is issued; a frame already in progress completes.
- s0_pixel / s1_pixel  in  DATA_WIDTH  source pixels.
- s0_valid / s1_valid  in  1  pixel valid.
- s0_frame_start / s1_frame_start  in  1  first pixel of a frame; qualified by the matching valid.
- s0_frame_end / s1_frame_end  in  1  last pixel of a frame; qualified by the matching valid.
- core_pixel  out  DATA_WIDTH  pixel to the core.
- core_valid  out  1  pixel valid to the core.
- core_frame_start  out  1  frame start to the core.
- core_frame_end  out  1  frame end to the core.
- core_done  in  1  core's output frame-end pulse.
- busy  out  1  high in FEED or DRAIN.
- grant_id  out  1  source owning the current or last frame.
- drop_cnt0 / drop_cnt1  out  CNT_WIDTH  saturating count of dropped frames per source.
- done_cnt  out  CNT_WIDTH  saturating count of frames completed by core_done.
- timeout_err  out  1  one-cycle pulse when a DRAIN abort occurs.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State is IDLE.
  - All outputs are 0: core_*, busy, grant_id, counters, timeout_err.
  - The round-robin pointer rr resets to 0, meaning src0 is preferred next.
  - Reset applied mid-frame aborts immediately; no core_frame_end is emitted.
- Request definition: reqN = sN_valid & sN_frame_start.
- IDLE:
  - If enable and any request, grant that source.
  - If both request, grant src rr; then set rr to the other source.
  - A single requester is granted regardless of rr; rr is set to the other source.
  - The granted frame_start pixel is forwarded next cycle with core_frame_start=1 and core_valid=1.
  - Pixel counter is set to 1. Go to FEED.
  - If the granted first pixel also has frame_end=1 (single-pixel frame), forward it with core_frame_end=1 and go to DRAIN.
- FEED (the grant source is fixed):
  - Each granted valid pixel is registered to core_pixel/core_valid, 1-cycle latency; core_valid is 0 otherwise.
  - A pixel ends the frame if its source frame_end=1 or the pixel count reaches WIDTH*HEIGHT.
  - On that pixel, core_frame_end=1 on the same forwarded cycle; go to DRAIN.
  - A second frame_start from the granted source during FEED is forwarded as an ordinary pixel and does not restart the frame.
- DRAIN:
  - core_valid is held 0. A watchdog counts from 0 each cycle.
  - core_done=1: increment done_cnt (saturating); go to IDLE.
  - Watchdog reaches TIMEOUT-1 without core_done: pulse timeout_err for one cycle; go to IDLE.
  - core_done on the same cycle as timeout takes precedence: counted as done, no error.
- Drops:
  - Any reqN from the non-granted source while busy increments drop_cntN.
  - In IDLE, a simultaneous non-selected request also increments drop_cntN.
  - Requests while enable=0 in IDLE count as drops.
  - Counters saturate at all-ones. A dropped frame's remaining pixels are ignored.
- busy and grant_id are registered and update on the cycle of the state change.
- core_done outside DRAIN is ignored.
- core_frame_start, core_frame_end and timeout_err are one-cycle pulses.

Optional Feature:
- Macro: DIST_SCHED_FIXED_PRIO_EN.
- Defined: src0 always wins simultaneous requests and rr is unused. src1 is granted only when src0 is not requesting.
- Undefined: round-robin as described above.

Test Plan (bench uses WIDTH=4, HEIGHT=2, TIMEOUT=16):
- Single frame: src0 sends 8 pixels 0x000001..0x000008 with start on pixel 1 and end on pixel 8; core_done pulses 5 cycles later.
  - Required: core_pixel mirrors the input with 1-cycle latency; core_frame_start with 0x000001; core_frame_end with 0x000008.
  - Required: busy falls the cycle after core_done; done_cnt=1.
- Simultaneous requests:
  - Round-robin (default build): src0 and src1 both start in the same cycle, twice in succession, each frame completed. Required: grants are src0 then src1; drop_cnt1=1, then drop_cnt0=1.
  - Fixed priority (DIST_SCHED_FIXED_PRIO_EN defined): same stimulus. Required: src0 granted both times; drop_cnt1=2.
- Drop while busy: src1 starts during src0's FEED and again during its DRAIN.
  - Required: no src1 pixel reaches the core; drop_cnt1=2.
- Timeout: frame fed and core_done never asserted.
  - Required: timeout_err pulses exactly 16 cycles after entering DRAIN; state returns to IDLE; done_cnt unchanged.
  - Done/timeout collision: core_done asserted on cycle 16 of DRAIN. Required: done_cnt increments and timeout_err stays 0.
- Overlength frame: src0 sends 10 pixels with no frame_end.
  - Required: core_frame_end on pixel 8; pixels 9-10 are not forwarded.
- Reset and enable:
  - rst=1 mid-FEED: all outputs are 0 next cycle.
  - enable=0 with a src0 request: no grant; drop_cnt0 increments.
  - drop_cnt0 driven with 300 requests: saturates at 255.

Source files
------------

// File: rtl/distortion_frame_scheduler.sv
// ---------------------------------------------------------------------------
// distortion_frame_scheduler
//
// This module lets two pixel-stream sources (src0 and src1) share one
// frame-buffered distortion core. Each frame goes to a single source.
//   - The granted frame is forwarded to the core through one register stage.
//   - While the core is busy, frames that start on the other source are
//     dropped and counted.
//   - After a frame has been fed, the scheduler waits in DRAIN for the core's
//     output frame end (core_done). A watchdog bounds this wait. Only after
//     DRAIN ends can the next frame be granted.
//
// Optional build macro:
//   DIST_SCHED_FIXED_PRIO_EN : when defined, src0 wins every simultaneous
//                              request. When undefined (the default),
//                              simultaneous requests alternate round-robin.
//
// Ports:
//   clk                    single clock
//   rst                    synchronous, active-high reset
//   enable                 when low, IDLE issues no new grant; a frame
//                          already in progress still completes
//   sN_pixel/valid         source pixel and its qualifier
//   sN_frame_start/end     first/last pixel of a frame (qualified by valid)
//   core_pixel/valid       registered pixel stream to the core
//   core_frame_start/end   one-cycle frame markers to the core
//   core_done              core's output frame-end pulse (used in DRAIN only)
//   busy                   high in FEED or DRAIN
//   grant_id               source owning the current or last frame
//   drop_cnt0/1            saturating count of dropped frames per source
//   done_cnt               saturating count of frames completed by core_done
//   timeout_err            one-cycle pulse when the DRAIN watchdog expires
// ---------------------------------------------------------------------------
module distortion_frame_scheduler #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 466,
  parameter int DATA_WIDTH = 24,
  parameter int TIMEOUT    = 1048576,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s0_pixel,
  input  logic                  s0_valid,
  input  logic                  s0_frame_start,
  input  logic                  s0_frame_end,
  input  logic [DATA_WIDTH-1:0] s1_pixel,
  input  logic                  s1_valid,
  input  logic                  s1_frame_start,
  input  logic                  s1_frame_end,
  output logic [DATA_WIDTH-1:0] core_pixel,
  output logic                  core_valid,
  output logic                  core_frame_start,
  output logic                  core_frame_end,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  grant_id,
  output logic [CNT_WIDTH-1:0]  drop_cnt0,
  output logic [CNT_WIDTH-1:0]  drop_cnt1,
  output logic [CNT_WIDTH-1:0]  done_cnt,
  output logic                  timeout_err
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int PC_W  = $clog2(TOTAL + 1);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PC_W-1:0]      PC_LAST = PC_W'(TOTAL - 1);
  localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic                  r_grant;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_core_pixel;
  logic                  r_core_valid;
  logic                  r_core_fs;
  logic                  r_core_fe;
  logic [PC_W-1:0]       r_pix_cnt;
  logic [WD_W-1:0]       r_wdog;
  logic [CNT_WIDTH-1:0]  r_drop0;
  logic [CNT_WIDTH-1:0]  r_drop1;
  logic [CNT_WIDTH-1:0]  r_done;
  logic                  r_timeout;
`ifndef DIST_SCHED_FIXED_PRIO_EN
  logic                  r_rr;  // source preferred at the next simultaneous request
`endif

  logic                  w_req0;
  logic                  w_req1;
  logic                  w_sel;
  logic                  w_src;
  logic [DATA_WIDTH-1:0] w_pixel;
  logic                  w_valid;
  logic                  w_fe;
  logic                  w_end_first;
  logic                  w_end_feed;
  logic                  w_drop0;
  logic                  w_drop1;

  assign w_req0 = s0_valid & s0_frame_start;
  assign w_req1 = s1_valid & s1_frame_start;

  // Winner of an IDLE arbitration. This value matters only when at least
  // one source is requesting.
`ifdef DIST_SCHED_FIXED_PRIO_EN
  assign w_sel = ~w_req0;
`else
  assign w_sel = (w_req0 & w_req1) ? r_rr : w_req1;
`endif

  // In IDLE the mux follows the arbitration winner. Once granted, it follows
  // the owning source.
  assign w_src   = (r_state == S_IDLE) ? w_sel : r_grant;
  assign w_pixel = w_src ? s1_pixel       : s0_pixel;
  assign w_valid = w_src ? s1_valid       : s0_valid;
  assign w_fe    = w_src ? s1_frame_end   : s0_frame_end;

  // A frame ends on its own frame_end or when it reaches the full pixel
  // count. This keeps an overlength frame from monopolising the core.
  assign w_end_first = w_fe | (TOTAL == 1);
  assign w_end_feed  = w_fe | (r_pix_cnt == PC_LAST);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the ifs leaves a latch behind.
  always_comb begin
    w_drop0 = 1'b0;
    w_drop1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (!enable) begin
        w_drop0 = w_req0;
        w_drop1 = w_req1;
      end else if (w_req0 & w_req1) begin
        w_drop0 = w_sel;
        w_drop1 = ~w_sel;
      end
    end else begin
      // Busy: only frames that start on the source not owning the core are
      // dropped.
      w_drop0 = w_req0 & r_grant;
      w_drop1 = w_req1 & ~r_grant;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_busy       <= 1'b0;
      r_core_pixel <= '0;
      r_core_valid <= 1'b0;
      r_core_fs    <= 1'b0;
      r_core_fe    <= 1'b0;
      r_pix_cnt    <= '0;
      r_wdog       <= '0;
      r_drop0      <= '0;
      r_drop1      <= '0;
      r_done       <= '0;
      r_timeout    <= 1'b0;
`ifndef DIST_SCHED_FIXED_PRIO_EN
      r_rr         <= 1'b0;
`endif
    end else begin
      r_core_valid <= 1'b0;
      r_core_fs    <= 1'b0;
      r_core_fe    <= 1'b0;
      r_timeout    <= 1'b0;

      if (w_drop0 && (r_drop0 != CNT_MAX)) r_drop0 <= r_drop0 + 1'b1;
      if (w_drop1 && (r_drop1 != CNT_MAX)) r_drop1 <= r_drop1 + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (enable && (w_req0 || w_req1)) begin
            r_grant      <= w_sel;
            r_busy       <= 1'b1;
`ifndef DIST_SCHED_FIXED_PRIO_EN
            r_rr         <= ~w_sel;
`endif
            r_core_pixel <= w_pixel;
            r_core_valid <= 1'b1;
            r_core_fs    <= 1'b1;
            r_pix_cnt    <= PC_W'(1);
            if (w_end_first) begin
              r_core_fe <= 1'b1;
              r_wdog    <= '0;
              r_state   <= S_DRAIN;
            end else begin
              r_state   <= S_FEED;
            end
          end
        end

        S_FEED: begin
          // Another frame_start from the owner is treated as an ordinary
          // pixel. Only the pixel count and frame_end can close the frame.
          if (w_valid) begin
            r_core_pixel <= w_pixel;
            r_core_valid <= 1'b1;
            r_pix_cnt    <= r_pix_cnt + 1'b1;
            if (w_end_feed) begin
              r_core_fe <= 1'b1;
              r_wdog    <= '0;
              r_state   <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // core_done is checked first, so it wins a tie with the watchdog.
          if (core_done) begin
            if (r_done != CNT_MAX) r_done <= r_done + 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_wdog == WD_LAST) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign core_pixel       = r_core_pixel;
  assign core_valid       = r_core_valid;
  assign core_frame_start = r_core_fs;
  assign core_frame_end   = r_core_fe;
  assign busy             = r_busy;
  assign grant_id         = r_grant;
  assign drop_cnt0        = r_drop0;
  assign drop_cnt1        = r_drop1;
  assign done_cnt         = r_done;
  assign timeout_err      = r_timeout;

endmodule

// File: tb/tb_distortion_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_distortion_frame_scheduler
//
// Bench for distortion_frame_scheduler, configured with WIDTH=4, HEIGHT=2
// and TIMEOUT=16.
//   - A frame-level reference model tracks who owns the core, how many
//     pixels have been fed, how long DRAIN has lasted, and the counters.
//   - The model predicts the DUT outputs for the cycle after each clock
//     edge.
//   - Directed scenarios are followed by randomized traffic.
//
// Build the bench with DIST_SCHED_FIXED_PRIO_EN defined to pair it with a
// fixed-priority DUT.
// ---------------------------------------------------------------------------
module tb_distortion_frame_scheduler;

  localparam int W       = 4;
  localparam int H       = 2;
  localparam int DW      = 24;
  localparam int TMO     = 16;
  localparam int CW      = 8;
  localparam int TOTAL   = W * H;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [DW-1:0] s0_pixel, s1_pixel;
  logic          s0_valid, s0_frame_start, s0_frame_end;
  logic          s1_valid, s1_frame_start, s1_frame_end;
  logic [DW-1:0] core_pixel;
  logic          core_valid, core_frame_start, core_frame_end;
  logic          core_done;
  logic          busy, grant_id, timeout_err;
  logic [CW-1:0] drop_cnt0, drop_cnt1, done_cnt;

  distortion_frame_scheduler #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .TIMEOUT(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s0_pixel(s0_pixel), .s0_valid(s0_valid),
    .s0_frame_start(s0_frame_start), .s0_frame_end(s0_frame_end),
    .s1_pixel(s1_pixel), .s1_valid(s1_valid),
    .s1_frame_start(s1_frame_start), .s1_frame_end(s1_frame_end),
    .core_pixel(core_pixel), .core_valid(core_valid),
    .core_frame_start(core_frame_start), .core_frame_end(core_frame_end),
    .core_done(core_done), .busy(busy), .grant_id(grant_id),
    .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1), .done_cnt(done_cnt),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_fwd = 0;   // core_valid cycles seen
  int n_leak = 0;  // forwarded pixels carrying the src1 tag 0x1xxxxx

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_FEED, M_DRAIN} mphase_t;
  mphase_t       m_phase = M_IDLE;
  int            m_gid = 0;
  int            m_fed = 0;    // pixels of the current frame already sent
  int            m_wait = 0;   // DRAIN cycles elapsed
  bit            m_rr = 1'b0;  // next preferred source on a tie
  int            m_drop [2] = '{0, 0};
  int            m_done = 0;
  logic [DW-1:0] e_pix = '0;
  bit            e_valid, e_fs, e_fe, e_to;

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Advance the model by one clock edge, using the inputs applied before it.
  task automatic model_step();
    bit            v [2];
    bit            fe [2];
    bit            req [2];
    logic [DW-1:0] px [2];
    int            w;
    v[0] = s0_valid;  v[1] = s1_valid;
    fe[0] = s0_frame_end; fe[1] = s1_frame_end;
    req[0] = s0_valid && s0_frame_start;
    req[1] = s1_valid && s1_frame_start;
    px[0] = s0_pixel; px[1] = s1_pixel;
    e_valid = 0; e_fs = 0; e_fe = 0; e_to = 0;
    if (rst) begin
      m_phase = M_IDLE; m_gid = 0; m_fed = 0; m_wait = 0; m_rr = 0;
      m_drop = '{0, 0}; m_done = 0; e_pix = '0;
      return;
    end
    case (m_phase)
      M_IDLE: begin
        if (!enable) begin
          for (int i = 0; i < 2; i++) if (req[i]) m_drop[i] = sat_inc(m_drop[i]);
        end else if (req[0] || req[1]) begin
          if (req[0] && req[1]) begin
`ifdef DIST_SCHED_FIXED_PRIO_EN
            w = 0;
`else
            w = m_rr ? 1 : 0;
`endif
            m_drop[1-w] = sat_inc(m_drop[1-w]);
          end else begin
            w = req[0] ? 0 : 1;
          end
          m_rr = (w == 0);
          m_gid = w; e_pix = px[w]; e_valid = 1; e_fs = 1; m_fed = 1;
          if (fe[w] || m_fed == TOTAL) begin
            e_fe = 1; m_wait = 0; m_phase = M_DRAIN;
          end else begin
            m_phase = M_FEED;
          end
        end
      end
      M_FEED: begin
        if (req[1-m_gid]) m_drop[1-m_gid] = sat_inc(m_drop[1-m_gid]);
        if (v[m_gid]) begin
          e_pix = px[m_gid]; e_valid = 1; m_fed++;
          if (fe[m_gid] || m_fed == TOTAL) begin
            e_fe = 1; m_wait = 0; m_phase = M_DRAIN;
          end
        end
      end
      default: begin
        if (req[1-m_gid]) m_drop[1-m_gid] = sat_inc(m_drop[1-m_gid]);
        m_wait++;
        if (core_done) begin
          m_done = sat_inc(m_done); m_phase = M_IDLE;
        end else if (m_wait == TMO) begin
          e_to = 1; m_phase = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("core_valid", core_valid, e_valid);
    if (e_valid) check("core_pixel", core_pixel, e_pix);
    check("core_frame_start", core_frame_start, e_fs);
    check("core_frame_end", core_frame_end, e_fe);
    check("busy", busy, m_phase != M_IDLE);
    check("grant_id", grant_id, m_gid);
    check("timeout_err", timeout_err, e_to);
    check("drop_cnt0", drop_cnt0, m_drop[0]);
    check("drop_cnt1", drop_cnt1, m_drop[1]);
    check("done_cnt", done_cnt, m_done);
    if (core_valid) n_fwd++;
    if (core_valid && core_pixel[23:20] == 4'h1) n_leak++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit v0, input bit fs0, input bit fe0, input logic [DW-1:0] p0,
                     input bit v1, input bit fs1, input bit fe1, input logic [DW-1:0] p1,
                     input bit done);
    s0_valid = v0; s0_frame_start = fs0; s0_frame_end = fe0; s0_pixel = p0;
    s1_valid = v1; s1_frame_start = fs1; s1_frame_end = fe1; s1_pixel = p1;
    core_done = done;
    tick();
  endtask

  task automatic idle_cyc(input bit done);
    cyc(0, 0, 0, '0, 0, 0, 0, '0, done);
  endtask

  // src0 pixels are 1..len and src1 pixels are 0x100001..; start marks
  // pixel 1 and, when mark_end is set, the end marks pixel len.
  task automatic feed(input bit use0, input bit use1, input int len, input bit mark_end);
    for (int i = 1; i <= len; i++)
      cyc(use0, use0 && i == 1, use0 && mark_end && i == len, DW'(i),
          use1, use1 && i == 1, use1 && mark_end && i == len, DW'(24'h100000 + i), 0);
  endtask

  task automatic core_finish(input int gap);
    for (int i = 0; i < gap; i++) idle_cyc(0);
    idle_cyc(1);
  endtask

  task automatic do_reset();
    rst = 1;
    idle_cyc(0);
    idle_cyc(0);
    rst = 0;
  endtask

  int seen;

  initial begin
    rst = 1; enable = 1;
    s0_pixel = '0; s0_valid = 0; s0_frame_start = 0; s0_frame_end = 0;
    s1_pixel = '0; s1_valid = 0; s1_frame_start = 0; s1_frame_end = 0;
    core_done = 0;
    do_reset();
    check("reset_busy", busy, 0);
    check("reset_done_cnt", done_cnt, 0);

    // Single frame, with core_done five cycles after the last pixel.
    feed(1, 0, 8, 1);
    for (int i = 0; i < 4; i++) idle_cyc(0);
    check("sf_busy_before_done", busy, 1);
    idle_cyc(1);
    check("sf_busy_fall", busy, 0);
    check("sf_done_cnt", done_cnt, 1);

    // Two back-to-back simultaneous starts.
    do_reset();
    feed(1, 1, 8, 1);
    core_finish(3);
    check("sim1_grant", grant_id, 0);
    check("sim1_drop1", drop_cnt1, 1);
    feed(1, 1, 8, 1);
    core_finish(3);
`ifdef DIST_SCHED_FIXED_PRIO_EN
    check("sim2_grant", grant_id, 0);
    check("sim2_drop0", drop_cnt0, 0);
    check("sim2_drop1", drop_cnt1, 2);
`else
    check("sim2_grant", grant_id, 1);
    check("sim2_drop0", drop_cnt0, 1);
    check("sim2_drop1", drop_cnt1, 1);
`endif

    // src1 starts once during FEED and once during DRAIN; both are dropped.
    do_reset();
    n_leak = 0;
    for (int i = 1; i <= 8; i++)
      cyc(1, i == 1, i == 8, DW'(i), i == 3 || i == 4, i == 3, 0, DW'(24'h100000 + i), 0);
    cyc(0, 0, 0, '0, 1, 1, 0, 24'h100077, 0);
    core_finish(2);
    check("drop_busy_cnt1", drop_cnt1, 2);
    check("drop_no_leak", n_leak, 0);

    // Watchdog expiry, then core_done colliding with the last DRAIN cycle.
    do_reset();
    feed(1, 0, 8, 1);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      idle_cyc(0);
      if (timeout_err && seen == 0) seen = k;
    end
    check("to_latency", seen, 16);
    check("to_done_cnt", done_cnt, 0);
    check("to_idle", busy, 0);
    feed(1, 0, 8, 1);
    core_finish(15);
    check("coll_done_cnt", done_cnt, 1);
    check("coll_no_err", timeout_err, 0);

    // Overlength frame: only the first TOTAL pixels reach the core.
    do_reset();
    n_fwd = 0;
    feed(1, 0, 10, 0);
    core_finish(2);
    check("ovl_forwarded", n_fwd, 8);

    // Reset mid-FEED, then requests while disabled.
    do_reset();
    feed(1, 0, 3, 0);
    rst = 1;
    cyc(1, 0, 0, 24'h4, 0, 0, 0, '0, 0);
    rst = 0;
    check("rst_valid", core_valid, 0);
    check("rst_busy", busy, 0);
    enable = 0;
    cyc(1, 1, 0, 24'h55, 0, 0, 0, '0, 0);
    check("dis_no_grant", busy, 0);
    check("dis_drop0", drop_cnt0, 1);
    for (int i = 0; i < 300; i++) cyc(1, 1, 0, 24'h55, 0, 0, 0, '0, 0);
    check("sat_drop0", drop_cnt0, 255);
    enable = 1;

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 9) != 0);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
          DW'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
          DW'($urandom),
          $urandom_range(0, 11) == 0);
    end
    rst = 0;
    idle_cyc(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
